// File: rtl/dcache_tag_array_nway_if.sv
// Request/response bundle between the dcache controller (master) and the tag array (slave).
interface dcache_tag_array_nway_if #(
    parameter int unsigned NUM_WAYS  = 2,
    parameter int unsigned SET_W     = 8,
    parameter int unsigned TAG_WIDTH = 20
);
    logic                          req_i;
    logic                          we_i;
    logic [SET_W-1:0]              set_i;
    logic [TAG_WIDTH-1:0]          tag_i;
    logic [NUM_WAYS-1:0]           way_en_i;
    logic [2:0]                    field_we_i;
    logic                          valid_i;
    logic                          dirty_i;
    logic                          flush_i;

    logic                          ready_o;
    logic                          rvalid_o;
    logic                          hit_o;
    logic [NUM_WAYS-1:0]           hit_way_o;
    logic                          hit_dirty_o;
    logic [NUM_WAYS-1:0]           victim_way_o;
    logic [NUM_WAYS*TAG_WIDTH-1:0] rtag_o;
    logic [NUM_WAYS-1:0]           rvalid_bits_o;
    logic [NUM_WAYS-1:0]           rdirty_bits_o;
    logic                          parity_err_o;

    modport master (
        output req_i, we_i, set_i, tag_i, way_en_i, field_we_i, valid_i, dirty_i, flush_i,
        input  ready_o, rvalid_o, hit_o, hit_way_o, hit_dirty_o, victim_way_o,
               rtag_o, rvalid_bits_o, rdirty_bits_o, parity_err_o
    );

    modport slave (
        input  req_i, we_i, set_i, tag_i, way_en_i, field_we_i, valid_i, dirty_i, flush_i,
        output ready_o, rvalid_o, hit_o, hit_way_o, hit_dirty_o, victim_way_o,
               rtag_o, rvalid_bits_o, rdirty_bits_o, parity_err_o
    );
endinterface

// File: rtl/dcache_tag_array_nway.sv
// N-way set-associative dcache tag array: per-way {tag, valid, dirty} storage with registered
// lookup, hit/victim decode, field-masked way writes and a hardware invalidate-all sweep that
// runs out of reset and on flush.
// Optional feature: define DCACHE_TAG_PARITY_EN to store an even-parity bit per way over
// {tag, valid, dirty}; a lookup parity mismatch forces that way to miss and count as invalid.
module dcache_tag_array_nway #(
    parameter int unsigned NUM_WAYS  = 2,
    parameter int unsigned NUM_SETS  = 256,
    parameter int unsigned TAG_WIDTH = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dcache_tag_array_nway_if.slave bus_if
);
    localparam int unsigned SET_W = $clog2(NUM_SETS);
    localparam int unsigned RR_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int          NW    = int'(NUM_WAYS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_FLUSH
    } state_e;

    // Storage (not reset; the sweep clears valid/dirty)
    logic [TAG_WIDTH-1:0] tag_mem [NUM_WAYS][NUM_SETS];
    logic                 vld_mem [NUM_WAYS][NUM_SETS];
    logic                 drt_mem [NUM_WAYS][NUM_SETS];
`ifdef DCACHE_TAG_PARITY_EN
    logic                 par_mem [NUM_WAYS][NUM_SETS];
    logic [NUM_WAYS-1:0]  wr_par_c;
    logic [NUM_WAYS-1:0]  rd_par_q;
`endif

    state_e               state_q, state_d;
    logic [SET_W-1:0]     ptr_q, ptr_d;
    logic                 ready_q;
    logic                 sweep_c;

    logic                 acc_c;
    logic                 lookup_c;
    logic                 rr_adv_c;
    logic                 wr_en_c;
    logic [SET_W-1:0]     wr_set_c;
    logic [NUM_WAYS-1:0]  wr_way_c;
    logic [2:0]           wr_mask_c;
    logic                 wr_valid_c;
    logic                 wr_dirty_c;

    logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] rd_tag_q;
    logic [NUM_WAYS-1:0]  rd_vld_q;
    logic [NUM_WAYS-1:0]  rd_drt_q;
    logic [TAG_WIDTH-1:0] cmp_tag_q;
    logic [RR_W-1:0]      rr_q;
    logic [RR_W-1:0]      rr_snap_q;
    logic                 rvalid_q;
    logic                 res_vld_q;

    logic [NUM_WAYS-1:0]  perr_c;
    logic [NUM_WAYS-1:0]  live_c;
    logic [NUM_WAYS-1:0]  match_c;
    logic [NUM_WAYS-1:0]  hit_way_c;
    logic [NUM_WAYS-1:0]  victim_c;
    logic                 hit_found_c;
    logic                 vic_found_c;

    // FSM state, sweep pointer and ready register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= (state_d == ST_IDLE);
        end
    end

    // FSM next state: IDLE serves requests, INIT/FLUSH sweep one set per cycle
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sweep_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus_if.flush_i) begin
                    state_d = ST_FLUSH;
                    ptr_d   = '0;
                end
            end
            ST_INIT, ST_FLUSH: begin
                sweep_c = 1'b1;
                if (ptr_q == SET_W'(NUM_SETS - 1)) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + SET_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Request acceptance and write-port muxing between sweep and controller writes
    always_comb begin
        acc_c      = bus_if.req_i & ready_q;
        lookup_c   = acc_c & ~bus_if.we_i;
        rr_adv_c   = acc_c & bus_if.we_i & bus_if.field_we_i[1] & bus_if.valid_i;
        wr_en_c    = sweep_c | (acc_c & bus_if.we_i);
        wr_set_c   = sweep_c ? ptr_q : bus_if.set_i;
        wr_way_c   = sweep_c ? {NUM_WAYS{1'b1}} : bus_if.way_en_i;
        wr_mask_c  = sweep_c ? 3'b011 : bus_if.field_we_i;
        wr_valid_c = sweep_c ? 1'b0 : bus_if.valid_i;
        wr_dirty_c = sweep_c ? 1'b0 : bus_if.dirty_i;
    end

`ifdef DCACHE_TAG_PARITY_EN
    // Parity of the merged entry (new fields where masked in, old fields elsewhere)
    always_comb begin
        wr_par_c = '0;
        for (int w = 0; w < NW; w++) begin
            wr_par_c[w] = ^{ (wr_mask_c[2] ? bus_if.tag_i : tag_mem[w][wr_set_c]),
                             (wr_mask_c[1] ? wr_valid_c   : vld_mem[w][wr_set_c]),
                             (wr_mask_c[0] ? wr_dirty_c   : drt_mem[w][wr_set_c]) };
        end
    end
`endif

    // Field-masked storage write, committed at the end of the accept cycle
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < NW; w++) begin
            if (wr_en_c && wr_way_c[w]) begin
                if (wr_mask_c[2]) tag_mem[w][wr_set_c] <= bus_if.tag_i;
                if (wr_mask_c[1]) vld_mem[w][wr_set_c] <= wr_valid_c;
                if (wr_mask_c[0]) drt_mem[w][wr_set_c] <= wr_dirty_c;
`ifdef DCACHE_TAG_PARITY_EN
                par_mem[w][wr_set_c] <= wr_par_c[w];
`endif
            end
        end
    end

    // Lookup read register: captures the set contents, compare tag and RR snapshot
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_tag_q  <= '0;
            rd_vld_q  <= '0;
            rd_drt_q  <= '0;
`ifdef DCACHE_TAG_PARITY_EN
            rd_par_q  <= '0;
`endif
            cmp_tag_q <= '0;
            rr_snap_q <= '0;
            rvalid_q  <= 1'b0;
            res_vld_q <= 1'b0;
        end else begin
            rvalid_q <= lookup_c;
            if (lookup_c) begin
                cmp_tag_q <= bus_if.tag_i;
                rr_snap_q <= rr_q;
                res_vld_q <= 1'b1;
                for (int w = 0; w < NW; w++) begin
                    rd_tag_q[w] <= tag_mem[w][bus_if.set_i];
                    rd_vld_q[w] <= vld_mem[w][bus_if.set_i];
                    rd_drt_q[w] <= drt_mem[w][bus_if.set_i];
`ifdef DCACHE_TAG_PARITY_EN
                    rd_par_q[w] <= par_mem[w][bus_if.set_i];
`endif
                end
            end
        end
    end

    // Round-robin replacement pointer, advanced by accepted valid-setting writes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else if (rr_adv_c) begin
            rr_q <= (rr_q == RR_W'(NUM_WAYS - 1)) ? '0 : rr_q + RR_W'(1);
        end
    end

    // Hit and victim decode from the captured set; lowest index wins in both cases
    always_comb begin
        perr_c      = '0;
        live_c      = '0;
        match_c     = '0;
        hit_way_c   = '0;
        victim_c    = '0;
        hit_found_c = 1'b0;
        vic_found_c = 1'b0;
        for (int w = 0; w < NW; w++) begin
`ifdef DCACHE_TAG_PARITY_EN
            perr_c[w] = (^{rd_tag_q[w], rd_vld_q[w], rd_drt_q[w]}) != rd_par_q[w];
`endif
            live_c[w]  = rd_vld_q[w] & ~perr_c[w];
            match_c[w] = live_c[w] & (rd_tag_q[w] == cmp_tag_q);
        end
        for (int w = 0; w < NW; w++) begin
            if (match_c[w] && !hit_found_c) begin
                hit_way_c[w] = 1'b1;
                hit_found_c  = 1'b1;
            end
            if (!live_c[w] && !vic_found_c) begin
                victim_c[w] = 1'b1;
                vic_found_c = 1'b1;
            end
        end
        if (!vic_found_c) begin
            victim_c = NUM_WAYS'(1) << rr_snap_q;
        end
    end

    assign bus_if.ready_o       = ready_q;
    assign bus_if.rvalid_o      = rvalid_q;
    assign bus_if.hit_o         = |match_c;
    assign bus_if.hit_way_o     = hit_way_c;
    assign bus_if.hit_dirty_o   = |(hit_way_c & rd_drt_q);
    assign bus_if.victim_way_o  = res_vld_q ? victim_c : '0;
    assign bus_if.rtag_o        = rd_tag_q;
    assign bus_if.rvalid_bits_o = rd_vld_q;
    assign bus_if.rdirty_bits_o = rd_drt_q;
    assign bus_if.parity_err_o  = |perr_c;

endmodule

// File: tb/tb_dcache_tag_array_nway.sv
// Randomized bench for dcache_tag_array_nway against an array-based behavioural model.
module tb_dcache_tag_array_nway;
    localparam int WAYS = 2;
    localparam int SETS = 256;
    localparam int TW   = 20;

    logic clk;
    logic rst;

    dcache_tag_array_nway_if #(.NUM_WAYS(WAYS), .SET_W(8), .TAG_WIDTH(TW)) tb_if ();

    dcache_tag_array_nway #(.NUM_WAYS(WAYS), .NUM_SETS(SETS), .TAG_WIDTH(TW)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (tb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the array contents
    logic [TW-1:0] m_tag   [WAYS][SETS];
    bit            m_vld   [WAYS][SETS];
    bit            m_drt   [WAYS][SETS];
    bit            m_known [WAYS][SETS];
    int            m_rr;

    int n_vec;
    int n_err;

    logic [TW-1:0] tag_pool [4] = '{20'h12345, 20'h00ABC, 20'hFFFFF, 20'h00000};

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic model_invalidate_all();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) begin
                m_vld[w][s] = 1'b0;
                m_drt[w][s] = 1'b0;
            end
    endtask

    task automatic idle_inputs();
        tb_if.req_i      = 1'b0;
        tb_if.we_i       = 1'b0;
        tb_if.set_i      = '0;
        tb_if.tag_i      = '0;
        tb_if.way_en_i   = '0;
        tb_if.field_we_i = '0;
        tb_if.valid_i    = 1'b0;
        tb_if.dirty_i    = 1'b0;
        tb_if.flush_i    = 1'b0;
    endtask

    // Ends on a falling edge with ready_o high, or records a timeout
    task automatic wait_ready();
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (tb_if.ready_o !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        if (tb_if.ready_o !== 1'b1) check_eq("ready_timeout", 64'(tb_if.ready_o), 64'd1);
    endtask

    // Counts rising edges while ready_o stays low
    task automatic count_busy(output int n);
        n = 0;
        while (tb_if.ready_o !== 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_lookup_result(input string name, input int s, input logic [TW-1:0] t);
        logic [WAYS-1:0]    ehit, evic, ev, ed;
        logic [WAYS*TW-1:0] etag, kmask;
        ehit = '0;
        evic = '0;
        for (int w = 0; w < WAYS; w++) begin
            ev[w] = m_vld[w][s];
            ed[w] = m_drt[w][s];
            etag[w*TW +: TW]  = m_tag[w][s];
            kmask[w*TW +: TW] = m_known[w][s] ? {TW{1'b1}} : {TW{1'b0}};
        end
        for (int w = 0; w < WAYS; w++)
            if (ev[w] && m_tag[w][s] == t && ehit == '0) ehit[w] = 1'b1;
        for (int w = 0; w < WAYS; w++)
            if (!ev[w] && evic == '0) evic[w] = 1'b1;
        if (evic == '0) evic = WAYS'(1) << m_rr;
        check_eq({name, ".rvalid"},    64'(tb_if.rvalid_o), 64'd1);
        check_eq({name, ".hit"},       64'(tb_if.hit_o), 64'(|ehit));
        check_eq({name, ".hit_way"},   64'(tb_if.hit_way_o), 64'(ehit));
        check_eq({name, ".hit_dirty"}, 64'(tb_if.hit_dirty_o), 64'(|(ehit & ed)));
        check_eq({name, ".victim"},    64'(tb_if.victim_way_o), 64'(evic));
        check_eq({name, ".vbits"},     64'(tb_if.rvalid_bits_o), 64'(ev));
        check_eq({name, ".dbits"},     64'(tb_if.rdirty_bits_o), 64'(ed));
        check_eq({name, ".rtag"},      64'(tb_if.rtag_o & kmask), 64'(etag & kmask));
        check_eq({name, ".perr"},      64'(tb_if.parity_err_o), 64'd0);
    endtask

    task automatic do_lookup(input string name, input int s, input logic [TW-1:0] t);
        wait_ready();
        tb_if.req_i = 1'b1;
        tb_if.we_i  = 1'b0;
        tb_if.set_i = 8'(s);
        tb_if.tag_i = t;
        @(posedge clk);
        #1;
        tb_if.req_i = 1'b0;
        check_lookup_result(name, s, t);
    endtask

    task automatic do_write(input int s, input logic [WAYS-1:0] ways, input logic [2:0] fm,
                            input logic [TW-1:0] t, input logic v, input logic d);
        wait_ready();
        tb_if.req_i      = 1'b1;
        tb_if.we_i       = 1'b1;
        tb_if.set_i      = 8'(s);
        tb_if.tag_i      = t;
        tb_if.way_en_i   = ways;
        tb_if.field_we_i = fm;
        tb_if.valid_i    = v;
        tb_if.dirty_i    = d;
        @(posedge clk);
        #1;
        tb_if.req_i = 1'b0;
        tb_if.we_i  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (ways[w]) begin
                if (fm[2]) begin
                    m_tag[w][s]   = t;
                    m_known[w][s] = 1'b1;
                end
                if (fm[1]) m_vld[w][s] = v;
                if (fm[0]) m_drt[w][s] = d;
            end
        end
        if (fm[1] && v) m_rr = (m_rr + 1) % WAYS;
        check_eq("write.rvalid", 64'(tb_if.rvalid_o), 64'd0);
    endtask

    initial begin
        int n;
        n_vec = 0;
        n_err = 0;
        m_rr  = 0;
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) begin
                m_tag[w][s]   = '0;
                m_known[w][s] = 1'b0;
            end
        model_invalidate_all();
        idle_inputs();

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst.ready",  64'(tb_if.ready_o), 64'd0);
        check_eq("rst.rvalid", 64'(tb_if.rvalid_o), 64'd0);
        check_eq("rst.hit",    64'(tb_if.hit_o), 64'd0);
        check_eq("rst.hitway", 64'(tb_if.hit_way_o), 64'd0);
        check_eq("rst.victim", 64'(tb_if.victim_way_o), 64'd0);
        check_eq("rst.vbits",  64'(tb_if.rvalid_bits_o), 64'd0);
        check_eq("rst.perr",   64'(tb_if.parity_err_o), 64'd0);
        rst = 1'b0;

        // T1: init sweep length, then a lookup finds nothing valid
        count_busy(n);
        check_eq("init_busy_cycles", 64'(n), 64'd256);
        do_lookup("t1", 77, 20'h0);
        do_lookup("t1b", 255, 20'h12345);

        // T2: single-way write then hit, then result hold
        do_write(5, 2'b10, 3'b111, 20'h12345, 1'b1, 1'b0);
        do_lookup("t2", 5, 20'h12345);
        @(posedge clk);
        #1;
        check_eq("t2.rvalid_drop", 64'(tb_if.rvalid_o), 64'd0);
        check_eq("t2.hit_hold",    64'(tb_if.hit_o), 64'd1);

        // T3: dirty-only write keeps tag and valid
        do_write(5, 2'b10, 3'b001, 20'h0F0F0, 1'b0, 1'b1);
        do_lookup("t3", 5, 20'h12345);
        do_lookup("t3m", 5, 20'h12346);

        // T4: full set, extra valid writes move the round-robin pointer
        do_write(9, 2'b01, 3'b111, 20'h00ABC, 1'b1, 1'b0);
        do_write(9, 2'b10, 3'b111, 20'h00DEF, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) do_write(9, 2'b01, 3'b111, 20'h00ABC, 1'b1, 1'b0);
        do_lookup("t4", 9, 20'h11111);
        do_lookup("t4h", 9, 20'h00DEF);

        // Random traffic over a small set range with a small tag pool
        for (int s = 0; s < 8; s++)
            do_write(s, 2'b11, 3'b111, tag_pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 4)
                do_write($urandom_range(0, 7), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                         tag_pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
            else
                do_lookup("rnd", $urandom_range(0, 15), tag_pool[$urandom_range(0, 3)]);
        end

        // T5: flush with a same-cycle lookup; requests and flush during the sweep are ignored
        do_write(5, 2'b10, 3'b111, 20'h12345, 1'b1, 1'b0);
        wait_ready();
        tb_if.req_i   = 1'b1;
        tb_if.we_i    = 1'b0;
        tb_if.set_i   = 8'd5;
        tb_if.tag_i   = 20'h12345;
        tb_if.flush_i = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        check_lookup_result("t5", 5, 20'h12345);
        model_invalidate_all();
        n = 0;
        while (tb_if.ready_o !== 1'b1 && n < 1000) begin
            if (n == 10) begin
                tb_if.req_i      = 1'b1;
                tb_if.we_i       = 1'b1;
                tb_if.set_i      = 8'd0;
                tb_if.tag_i      = 20'h55555;
                tb_if.way_en_i   = 2'b11;
                tb_if.field_we_i = 3'b111;
                tb_if.valid_i    = 1'b1;
                tb_if.dirty_i    = 1'b1;
            end
            if (n == 20) idle_inputs();
            if (n == 30) tb_if.flush_i = 1'b1;
            if (n == 31) tb_if.flush_i = 1'b0;
            @(posedge clk);
            #1;
            n++;
            if (n > 10 && n <= 21) check_eq("t5.rvalid_in_sweep", 64'(tb_if.rvalid_o), 64'd0);
        end
        idle_inputs();
        check_eq("flush_busy_cycles", 64'(n), 64'd256);
        do_lookup("t5s5", 5, 20'h12345);
        do_lookup("t5s0", 0, 20'h55555);

        // T6: reset in the middle of a sweep restarts it from set 0
        do_write(3, 2'b01, 3'b111, 20'h0ABCD, 1'b1, 1'b1);
        wait_ready();
        tb_if.flush_i = 1'b1;
        @(posedge clk);
        #1;
        tb_if.flush_i = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6.rst_ready", 64'(tb_if.ready_o), 64'd0);
        rst = 1'b0;
        model_invalidate_all();
        m_rr = 0;
        count_busy(n);
        check_eq("reinit_busy_cycles", 64'(n), 64'd256);
        do_lookup("t6", 3, 20'h0ABCD);
        do_write(9, 2'b11, 3'b111, 20'h00777, 1'b1, 1'b0);
        do_lookup("t6rr", 9, 20'h00001);

`ifdef DCACHE_TAG_PARITY_EN
        // Corrupt one stored tag bit; the way must miss and report a parity error
        do_write(3, 2'b01, 3'b111, 20'h0ABCD, 1'b1, 1'b0);
        @(negedge clk);
        dut.tag_mem[0][3] = dut.tag_mem[0][3] ^ 20'h1;
        wait_ready();
        tb_if.req_i = 1'b1;
        tb_if.we_i  = 1'b0;
        tb_if.set_i = 8'd3;
        tb_if.tag_i = 20'h0ABCC;
        @(posedge clk);
        #1;
        tb_if.req_i = 1'b0;
        check_eq("par.perr",   64'(tb_if.parity_err_o), 64'd1);
        check_eq("par.hit",    64'(tb_if.hit_o), 64'd0);
        check_eq("par.victim", 64'(tb_if.victim_way_o), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
